// File: rtl/skid_buff_pkg.sv
// Shared types for the two-entry DTI skid buffer.
// The buffer FSM state and the default data width of the DTI interface.
package skid_buff_pkg;

    localparam int DTI_DEFAULT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/skid_buff_if.sv
// DTI valid/ready stream.
// The producer drives valid/data and the consumer drives ready.
interface dti
    import skid_buff_pkg::*;
#(
    parameter int W = DTI_DEFAULT_W
) ();

    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport producer (
        output valid,
        output data,
        input  ready
    );

    modport consumer (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/skid_buff.sv
// Two-entry skid buffer between DTI streams.
// din.ready, dout.valid and dout.data all come straight from flops, which breaks the ready timing chain.
module skid_buff
    import skid_buff_pkg::*;
(
    input  logic clk,
    input  logic rst,
    dti.consumer din,
    dti.producer dout
);

    localparam int W = $size(din.data);

    if ($size(din.data) != $size(dout.data)) begin : g_width_check
        $error("skid_buff: din.data and dout.data widths differ");
    end

    skid_state_t  state;
    skid_state_t  next_state;
    logic [W-1:0] main_reg;
    logic [W-1:0] skid_reg;
    logic         ready_reg;

    logic         in_fire;
    logic         out_fire;
    logic         load_main;
    logic         main_from_skid;
    logic         load_skid;

    assign in_fire  = din.valid && ready_reg;
    assign out_fire = (state != EMPTY) && dout.ready;

    // ready is registered from next_state, so it is already low during the first FULL cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            ready_reg <= 1'b0;
        end else begin
            state     <= next_state;
            ready_reg <= (next_state != FULL);
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            EMPTY: begin
                if (in_fire) next_state = BUSY;
            end
            BUSY: begin
                if (in_fire && !out_fire)      next_state = FULL;
                else if (!in_fire && out_fire) next_state = EMPTY;
            end
            FULL: begin
                if (out_fire) next_state = BUSY;
            end
            default: next_state = EMPTY;
        endcase
    end

    // The skid entry only ever holds the beat younger than main.
    always_comb begin
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            EMPTY: begin
                load_main = in_fire;
            end
            BUSY: begin
                load_main = in_fire && out_fire;
                load_skid = in_fire && !out_fire;
            end
            FULL: begin
                load_main      = out_fire;
                main_from_skid = out_fire;
            end
            default: begin
                load_main = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_reg <= '0;
            skid_reg <= '0;
        end else begin
            if (load_main) main_reg <= main_from_skid ? skid_reg : din.data;
            if (load_skid) skid_reg <= din.data;
        end
    end

    assign dout.valid = (state != EMPTY);
    assign dout.data  = main_reg;
    assign din.ready  = ready_reg;

endmodule
